instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 32, giving the PC and instruction width.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 The block SHALL have one clock and a synchronous active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-004 The block SHALL have ports: imem_req_valid output 1, fetch request valid; imem_req_ready input 1, memory accepts request; imem_req_addr output ADDRESS_WIDTH, word-aligned fetch address.
REQ-005 The block SHALL have ports: imem_rsp_valid input 1, read data valid; imem_rsp_data input ADDRESS_WIDTH, instruction word.
REQ-006 The block SHALL have ports: instr output ADDRESS_WIDTH, instruction to control unit; instr_pc output ADDRESS_WIDTH, PC of instr; instr_valid output 1; instr_ready input 1, consumer accepts.
REQ-007 The block SHALL have ports: PCsrc input 1, branch taken for the instruction being accepted; ImmOp input ADDRESS_WIDTH, sign-extended branch offset.

Function
REQ-008 The block SHALL transfer a request when imem_req_valid && imem_req_ready, and an instruction when instr_valid && instr_ready.
REQ-009 Memory responses SHALL return in request order, at least one cycle after acceptance, with no backpressure on the response.
REQ-010 The block SHALL keep a fetch PC, advance it by 4 per accepted request, and wrap modulo 2^ADDRESS_WIDTH.
REQ-011 The block SHALL hold at most 2 outstanding requests and SHALL assert imem_req_valid only if outstanding plus buffered entries < 2.
REQ-012 Returned words and their PCs SHALL enter a 2-entry FIFO, with the head driving instr, instr_pc and instr_valid (not-empty).
REQ-013 Once asserted, imem_req_valid and imem_req_addr SHALL stay stable until accepted, except on redirect.
REQ-014 PCsrc SHALL be sampled only when instr_valid && instr_ready; with PCsrc=1 the fetch PC SHALL become instr_pc + ImmOp, truncated to ADDRESS_WIDTH.
REQ-015 On redirect the block SHALL clear the FIFO in the same edge, drop any unaccepted request, and record the outstanding count as responses to discard.
REQ-016 The FSM SHALL have states FETCH (normal), DRAIN (discarding stale responses, no requests issued), RESET_WAIT (one cycle after reset, no requests).
REQ-017 Transitions: RESET_WAIT->FETCH unconditionally; FETCH->DRAIN on redirect with outstanding>0; FETCH->FETCH on redirect with outstanding==0; DRAIN->FETCH when the last stale response arrives.
REQ-018 A response arriving in the same cycle as a redirect SHALL be discarded.
REQ-019 FIFO push and pop in the same cycle SHALL keep occupancy unchanged; push when full SHALL never occur, by REQ-011.
REQ-020 Bits [1:0] of ImmOp SHALL be ignored, so the target is forced word-aligned.
REQ-021 Latency: with imem_req_ready=1 and a 1-cycle memory, the first instr_valid SHALL assert 3 cycles after rst deasserts.

Reset
REQ-022 While rst=1 the block SHALL set fetch PC=RESET_PC, FIFO empty, outstanding=0, discard=0, state=RESET_WAIT, imem_req_valid=0, instr_valid=0, imem_req_addr=RESET_PC, instr=0, instr_pc=0.
REQ-023 Reset mid-operation SHALL abandon all in-flight responses; responses arriving after reset deasserts for pre-reset requests SHALL NOT occur (memory is reset together).

Configuration
REQ-024 With FETCH_REDIRECT_COUNT_EN defined, the block SHALL add output redirect_count (32 bits), reset to 0, incremented by 1 per redirect and wrapping at 2^32.
REQ-025 With FETCH_REDIRECT_COUNT_EN undefined, the port and counter SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-026 Package fetch_pkg SHALL hold the state enum (RESET_WAIT, FETCH, DRAIN), FIFO_DEPTH=2 and the PC increment constant 4.
REQ-027 The FIFO SHALL be a sub-module fetch_fifo (parameterised width, depth 2, push/pop/flush, full/empty).

Verification
REQ-028 Reset release, ready=1, 1-cycle memory -> addresses 0x0,0x4,0x8 requested on consecutive cycles; first instr_valid at cycle 3 with instr_pc=0x0.
REQ-029 instr_ready=0 for 10 cycles -> at most 2 requests issued, FIFO full, imem_req_valid=0; instr_ready=1 -> resumes at next address, no loss or duplication.
REQ-030 Accept instr_pc=0x10 with PCsrc=1, ImmOp=0xFFFF_FFF8 while 2 outstanding -> both stale responses dropped; next instr_pc=0x08.
REQ-031 imem_req_ready low 5 cycles -> imem_req_addr held stable; random response delays 1-4 cycles -> instructions delivered in PC order.
REQ-032 Redirect when instr_pc=0xFFFF_FFFC, ImmOp=8 -> target wraps to 0x4; with FETCH_REDIRECT_COUNT_EN, redirect_count increments to 1.
REQ-033 Assert rst during DRAIN -> next cycle all outputs at reset values; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    FETCH      = 2'd1,
    DRAIN      = 2'd2
  } fetch_state_e;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned PC_INCR    = 4;
  // Counter width able to hold 0..FIFO_DEPTH, plus one bit for sums of two counters.
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned SUM_W      = CNT_W + 1;

  // True when in-flight requests plus buffered words leave room for one more request.
  function automatic logic has_room(input logic [CNT_W-1:0] outst,
                                    input logic [CNT_W-1:0] buffered);
    return (SUM_W'(outst) + SUM_W'(buffered)) < SUM_W'(FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry shift FIFO; entry 0 is always the head so the head output comes straight from a flop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [WIDTH-1:0] data_d [FIFO_DEPTH];
  logic [CNT_W-1:0] count_q, count_d, count_kept;

  // Pop shifts entry 1 forward; push lands in the first free slot after the pop.
  always_comb begin
    data_d     = data_q;
    count_kept = count_q;
    if (pop && (count_q != '0)) begin
      data_d[0]  = data_q[1];
      count_kept = count_q - CNT_W'(1);
    end
    count_d = count_kept;
    if (push && (count_kept < CNT_W'(FIFO_DEPTH))) begin
      if (count_kept == '0) begin
        data_d[0] = push_data;
      end else begin
        data_d[1] = push_data;
      end
      count_d = count_kept + CNT_W'(1);
    end
    if (flush) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '{default: '0};
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign head_data = data_q[0];
  assign count     = count_q;
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: in-order memory requests, 2-entry instruction buffer, branch redirect with stale-response drain.
// Optional FETCH_REDIRECT_COUNT_EN adds a 32-bit redirect_count output.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(32'h0000_0000)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [ADDRESS_WIDTH-1:0] imem_rsp_data,
  output logic [ADDRESS_WIDTH-1:0] instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  input  logic                     PCsrc,
  input  logic [ADDRESS_WIDTH-1:0] ImmOp
`ifdef FETCH_REDIRECT_COUNT_EN
  ,
  output logic [31:0]              redirect_count
`endif
);

  localparam int unsigned     AW         = ADDRESS_WIDTH;
  localparam logic [AW-1:0]   ALIGN_MASK = ~AW'(3);

  fetch_state_e     state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [AW-1:0]    rsp_pc_q, rsp_pc_d;
  logic             req_valid_q, req_valid_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic             req_fire, instr_fire, redirect, push;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count, outst_next, buf_next;
  logic [AW-1:0]    target;
  logic [2*AW-1:0]  fifo_head;

  assign req_fire   = req_valid_q && imem_req_ready;
  assign instr_fire = !fifo_empty && instr_ready;
  assign redirect   = instr_fire && PCsrc;
  assign target     = instr_pc + (ImmOp & ALIGN_MASK);
  // Only FETCH keeps responses; a response racing a redirect is stale.
  assign push       = imem_rsp_valid && (state_q == FETCH) && !redirect && !fifo_full;
  assign outst_next = outst_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
  assign buf_next   = fifo_count + CNT_W'(push) - CNT_W'(instr_fire);

  fetch_fifo #(
    .WIDTH (2 * AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({rsp_pc_q, imem_rsp_data}),
    .pop       (instr_fire),
    .flush     (redirect),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Request valid is registered, so it is computed from next-cycle occupancy.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rsp_pc_d    = rsp_pc_q;
    req_valid_d = req_valid_q;
    outst_d     = outst_next;
    discard_d   = discard_q;
    if (req_fire) begin
      pc_d = pc_q + AW'(PC_INCR);
    end
    if (push) begin
      rsp_pc_d = rsp_pc_q + AW'(PC_INCR);
    end
    case (state_q)
      RESET_WAIT: begin
        state_d     = FETCH;
        req_valid_d = 1'b1;
      end
      FETCH: begin
        if (redirect) begin
          pc_d      = target;
          rsp_pc_d  = target;
          discard_d = outst_next;
          if (outst_next != '0) begin
            state_d     = DRAIN;
            req_valid_d = 1'b0;
          end else begin
            req_valid_d = 1'b1;
          end
        end else begin
          req_valid_d = has_room(outst_next, buf_next);
        end
      end
      DRAIN: begin
        req_valid_d = 1'b0;
        if (imem_rsp_valid) begin
          discard_d = discard_q - CNT_W'(1);
          if (discard_q == CNT_W'(1)) begin
            state_d     = FETCH;
            req_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d     = RESET_WAIT;
        req_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_WAIT;
      pc_q        <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
      outst_q     <= '0;
      discard_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rsp_pc_q    <= rsp_pc_d;
      req_valid_q <= req_valid_d;
      outst_q     <= outst_d;
      discard_q   <= discard_d;
    end
  end

  assign imem_req_valid    = req_valid_q;
  assign imem_req_addr     = pc_q;
  assign {instr_pc, instr} = fifo_head;
  assign instr_valid       = !fifo_empty;

`ifdef FETCH_REDIRECT_COUNT_EN
  logic [31:0] redirect_count_q, redirect_count_d;

  always_comb begin
    redirect_count_d = redirect_count_q;
    if (redirect) begin
      redirect_count_d = redirect_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_count_q <= '0;
    end else begin
      redirect_count_q <= redirect_count_d;
    end
  end

  assign redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with an in-order instruction memory model of configurable latency.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr, instr_pc;
  logic        instr_valid, instr_ready;
  logic        PCsrc;
  logic [31:0] ImmOp;
`ifdef FETCH_REDIRECT_COUNT_EN
  logic [31:0] redirect_count;
`endif

  always #5 clk = ~clk;

  instr_fetch #(
    .ADDRESS_WIDTH (32),
    .RESET_PC      (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .PCsrc          (PCsrc),
    .ImmOp          (ImmOp)
`ifdef FETCH_REDIRECT_COUNT_EN
    ,
    .redirect_count (redirect_count)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] req_log[$];
  logic [31:0] ipc_log[$];
  logic [31:0] idata_log[$];
  logic [31:0] redir_pc[$];
  logic [31:0] redir_imm[$];
  int          dly_tab[4];
  int          cyc, last_due;
  int          checks, failures;
  int          first_v;
  logic [31:0] first_pc, first_ins;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // 0: accepted instr PCs, 1: accepted request addresses, 2: accepted instr words
  function automatic logic [31:0] at(input int which, input int i);
    case (which)
      0:       return (i < ipc_log.size())   ? ipc_log[i]   : 32'hBAD0_BAD0;
      1:       return (i < req_log.size())   ? req_log[i]   : 32'hBAD0_BAD0;
      default: return (i < idata_log.size()) ? idata_log[i] : 32'hBAD0_BAD0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive memory response and branch inputs for the cycle just begun.
  task automatic drive_post();
    if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    if (instr_valid && redir_pc.size() > 0 && instr_pc == redir_pc[0]) begin
      PCsrc = 1'b1;
      ImmOp = redir_imm[0];
    end else begin
      PCsrc = 1'b0;
      ImmOp = '0;
    end
  endtask

  // Record handshakes that complete at the coming edge, advance one clock, then drive.
  task automatic tick();
    bit req_fire, rsp_fire, ins_fire;
    req_fire = imem_req_valid && imem_req_ready;
    rsp_fire = imem_rsp_valid;
    ins_fire = instr_valid && instr_ready;
    if (rst) begin
      mq.delete();
    end else begin
      if (rsp_fire) void'(mq.pop_front());
      if (req_fire) begin
        int d;
        d = cyc + dly_tab[req_log.size() % 4];
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        mq.push_back('{addr: imem_req_addr, due: d});
        req_log.push_back(imem_req_addr);
      end
      if (ins_fire) begin
        ipc_log.push_back(instr_pc);
        idata_log.push_back(instr);
        if (PCsrc) begin
          void'(redir_pc.pop_front());
          void'(redir_imm.pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    drive_post();
  endtask

  task automatic clear_logs();
    req_log.delete();
    ipc_log.delete();
    idata_log.delete();
    redir_pc.delete();
    redir_imm.delete();
    cyc      = 0;
    last_due = 0;
  endtask

  // Leaves the bench in cycle 0: rst just released, the DUT still in RESET_WAIT.
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    clear_logs();
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"},   32'(imem_req_valid), 32'h0);
    check({tag, "_req_addr"},    imem_req_addr,       32'h0);
    check({tag, "_instr_valid"}, 32'(instr_valid),    32'h0);
    check({tag, "_instr"},       instr,               32'h0);
    check({tag, "_instr_pc"},    instr_pc,            32'h0);
`ifdef FETCH_REDIRECT_COUNT_EN
    check({tag, "_redir_cnt"},   redirect_count,      32'h0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; last_due = 0;
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    instr_ready = 1'b0; PCsrc = 1'b0; ImmOp = '0;
    dly_tab = '{1, 1, 1, 1};

    // Reset values
    tick(); tick();
    check_reset_outputs("rst");

    // First-fetch latency and steady streaming with a 1-cycle memory
    imem_req_ready = 1'b1; instr_ready = 1'b1; dly_tab = '{1, 1, 1, 1};
    do_reset();
    tick();
    check("lat_req_valid_c1", 32'(imem_req_valid), 32'h1);
    check("lat_req_addr_c1",  imem_req_addr,       32'h0);
    first_v = 0; first_pc = '1; first_ins = '1;
    for (int i = 0; i < 12 && first_v == 0; i++) begin
      if (instr_valid === 1'b1) begin
        first_v = cyc; first_pc = instr_pc; first_ins = instr;
      end else begin
        tick();
      end
    end
    check("lat_first_cycle", 32'(first_v), 32'd3);
    check("lat_first_pc",    first_pc,     32'h0);
    check("lat_first_instr", first_ins,    mem_word(32'h0));
    repeat (20) tick();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("stream_req%0d", i),  at(1, i), 32'(4 * i));
      check($sformatf("stream_pc%0d", i),   at(0, i), 32'(4 * i));
      check($sformatf("stream_data%0d", i), at(2, i), mem_word(32'(4 * i)));
    end

    // Consumer stall: buffer fills, requests stop, then resume without loss
    instr_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    check("stall_nreq",        32'(req_log.size()), 32'd2);
    check("stall_instr_valid", 32'(instr_valid),    32'h1);
    check("stall_req_valid",   32'(imem_req_valid), 32'h0);
    check("stall_head_pc",     instr_pc,            32'h0);
    instr_ready = 1'b1;
    repeat (30) tick();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("resume_req%0d", i), at(1, i), 32'(4 * i));
      check($sformatf("resume_pc%0d", i),  at(0, i), 32'(4 * i));
    end

    // Backward branch at 0x10 with stale requests in flight
    dly_tab = '{2, 2, 2, 2};
    do_reset();
    redir_pc.push_back(32'h10); redir_imm.push_back(32'hFFFF_FFF8);
    repeat (60) tick();
    begin
      logic [31:0] exp_pc[10] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10,
                                  32'h8, 32'hC, 32'h10, 32'h14, 32'h18};
      for (int i = 0; i < 10; i++) begin
        check($sformatf("br_pc%0d", i),   at(0, i), exp_pc[i]);
        check($sformatf("br_data%0d", i), at(2, i), mem_word(exp_pc[i]));
      end
    end
`ifdef FETCH_REDIRECT_COUNT_EN
    check("br_redir_cnt", redirect_count, 32'd1);
`endif

    // Memory stall holds the request; mixed response latencies keep PC order
    dly_tab = '{1, 3, 2, 4}; imem_req_ready = 1'b0;
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_valid%0d", i), 32'(imem_req_valid), 32'h1);
      check($sformatf("hold_addr%0d", i),  imem_req_addr,       32'h0);
      tick();
    end
    imem_req_ready = 1'b1;
    repeat (60) tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("lat_mix_req%0d", i),  at(1, i), 32'(4 * i));
      check($sformatf("lat_mix_pc%0d", i),   at(0, i), 32'(4 * i));
      check($sformatf("lat_mix_data%0d", i), at(2, i), mem_word(32'(4 * i)));
    end

    // Branch to the top of memory with ImmOp[1:0] set; sequential PC wraps to 0
    dly_tab = '{1, 1, 1, 1};
    do_reset();
    redir_pc.push_back(32'h0); redir_imm.push_back(32'hFFFF_FFFB);
    repeat (30) tick();
    begin
      logic [31:0] exp_pc[5] = '{32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
      for (int i = 0; i < 5; i++) begin
        check($sformatf("wrap_seq_pc%0d", i), at(0, i), exp_pc[i]);
      end
    end

    // Branch at 0xFFFF_FFFC by +8 wraps the target to 0x4
    do_reset();
    redir_pc.push_back(32'h0);         redir_imm.push_back(32'hFFFF_FFFC);
    redir_pc.push_back(32'hFFFF_FFFC); redir_imm.push_back(32'h8);
    repeat (30) tick();
    begin
      logic [31:0] exp_pc[5] = '{32'h0, 32'hFFFF_FFFC, 32'h4, 32'h8, 32'hC};
      for (int i = 0; i < 5; i++) begin
        check($sformatf("wrap_br_pc%0d", i), at(0, i), exp_pc[i]);
      end
    end
`ifdef FETCH_REDIRECT_COUNT_EN
    check("wrap_br_redir_cnt", redirect_count, 32'd2);
`endif

    // Reset while draining a stale response; fetch restarts at RESET_PC
    dly_tab = '{1, 4, 4, 4};
    do_reset();
    redir_pc.push_back(32'h0); redir_imm.push_back(32'h40);
    repeat (4) tick();
    check("drain_req_valid",   32'(imem_req_valid), 32'h0);
    check("drain_instr_valid", 32'(instr_valid),    32'h0);
    check("drain_redir_taken", 32'(ipc_log.size()), 32'd1);
    rst = 1'b1;
    tick();
    check_reset_outputs("drain_rst");
    clear_logs();
    rst = 1'b0;
    tick();
    check("restart_req_valid", 32'(imem_req_valid), 32'h1);
    check("restart_req_addr",  imem_req_addr,       32'h0);
    repeat (20) tick();
    check("restart_pc0", at(0, 0), 32'h0);
    check("restart_pc1", at(0, 1), 32'h4);
    check("restart_pc2", at(0, 2), 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
